// File: rtl/argument_pop_scheduler.sv
// Field sequencer between an argument_decoder window and a valid/ready consumer.
// Optional feature macro: ARG_SCHED_COUNT_EN adds the arg_count transfer counter.
module argument_pop_scheduler #(
    parameter int WIDTH_OUT      = 8,
    parameter int LOG2_WIDTH_OUT = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic [WIDTH_OUT-1:0]      dec_q,
    input  logic                      dec_ready,
    output logic [LOG2_WIDTH_OUT:0]   dec_pop,
    output logic                      arg_valid,
    input  logic                      arg_ready,
    output logic [1:0]                arg_op,
    output logic [LOG2_WIDTH_OUT:0]   arg_len,
    output logic [WIDTH_OUT-1:0]      arg_data,
`ifdef ARG_SCHED_COUNT_EN
    output logic [15:0]               arg_count,
`endif
    output logic                      busy
);

    localparam int LW = LOG2_WIDTH_OUT + 1;

    typedef enum logic [2:0] {
        S_HDR,
        S_HWAIT,
        S_ESC,
        S_EWAIT,
        S_ARG,
        S_AWAIT
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;

    logic [1:0]            r_op;
    logic [LW-1:0]         r_len;
    logic [LW-1:0]         r_pop;
    logic                  r_arg_valid;
    logic [1:0]            r_arg_op;
    logic [LW-1:0]         r_arg_len;
    logic [WIDTH_OUT-1:0]  r_arg_data;

    logic                  w_hdr_take;
    logic                  w_esc_take;
    logic                  w_arg_take;
    logic [LW-1:0]         w_esc_len;
    logic [WIDTH_OUT-1:0]  w_mask;
    logic [LW-1:0]         w_pop_nxt;
    logic [1:0]            w_op_nxt;
    logic [LW-1:0]         w_len_nxt;
    logic                  w_valid_nxt;
    logic                  w_load;

    function automatic logic [LW-1:0] hdr_len(input logic [1:0] op);
        case (op)
            2'b00:   return LW'(1);
            2'b01:   return LW'(2);
            2'b10:   return LW'(4);
            default: return '0;
        endcase
    endfunction

    // An escape value of zero stands for a full-window argument.
    assign w_esc_len  = (dec_q[LOG2_WIDTH_OUT-1:0] == '0) ? LW'(WIDTH_OUT)
                                                         : {1'b0, dec_q[LOG2_WIDTH_OUT-1:0]};
    assign w_hdr_take = (r_state == S_HDR) & en & dec_ready;
    assign w_esc_take = (r_state == S_ESC) & dec_ready;
    assign w_arg_take = (r_state == S_ARG) & dec_ready & (~r_arg_valid | arg_ready);

    // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
    always_comb begin
        w_mask = '0;
        for (int i = 0; i < WIDTH_OUT; i++) begin
            w_mask[i] = (LW'(i) < r_len);
        end
    end

    // NOTE: state and datapath registers use non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_HDR;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_HDR:   if (w_hdr_take) w_state_nxt = S_HWAIT;
            S_HWAIT: w_state_nxt = (r_op == 2'b11) ? S_ESC : S_ARG;
            S_ESC:   if (w_esc_take) w_state_nxt = S_EWAIT;
            S_EWAIT: w_state_nxt = S_ARG;
            S_ARG:   if (w_arg_take) w_state_nxt = S_AWAIT;
            S_AWAIT: w_state_nxt = S_HDR;
            default: w_state_nxt = S_HDR;
        endcase
    end

    always_comb begin
        w_pop_nxt   = '0;
        w_op_nxt    = r_op;
        w_len_nxt   = r_len;
        w_valid_nxt = r_arg_valid & ~arg_ready;
        w_load      = 1'b0;
        case (r_state)
            S_HDR: begin
                if (w_hdr_take) begin
                    w_pop_nxt = LW'(2);
                    w_op_nxt  = dec_q[1:0];
                    w_len_nxt = hdr_len(dec_q[1:0]);
                end
            end
            S_ESC: begin
                if (w_esc_take) begin
                    w_pop_nxt = LW'(LOG2_WIDTH_OUT);
                    w_len_nxt = w_esc_len;
                end
            end
            S_ARG: begin
                // A load in the same cycle as a transfer replaces the old field without a bubble.
                if (w_arg_take) begin
                    w_pop_nxt   = r_len;
                    w_valid_nxt = 1'b1;
                    w_load      = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_op        <= '0;
            r_len       <= '0;
            r_pop       <= '0;
            r_arg_valid <= 1'b0;
            r_arg_op    <= '0;
            r_arg_len   <= '0;
            r_arg_data  <= '0;
        end else begin
            r_op        <= w_op_nxt;
            r_len       <= w_len_nxt;
            r_pop       <= w_pop_nxt;
            r_arg_valid <= w_valid_nxt;
            if (w_load) begin
                r_arg_op   <= r_op;
                r_arg_len  <= r_len;
                r_arg_data <= dec_q & w_mask;
            end
        end
    end

`ifdef ARG_SCHED_COUNT_EN
    logic [15:0] r_count;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_count <= '0;
        end else if (r_arg_valid & arg_ready) begin
            r_count <= r_count + 16'd1;
        end
    end

    assign arg_count = r_count;
`endif

    assign dec_pop   = r_pop;
    assign arg_valid = r_arg_valid;
    assign arg_op    = r_arg_op;
    assign arg_len   = r_arg_len;
    assign arg_data  = r_arg_data;
    assign busy      = (r_state != S_HDR) | r_arg_valid;

endmodule

// File: tb/tb_argument_pop_scheduler.sv
// Bench for argument_pop_scheduler: bit-queue decoder model plus a stream-level
// parser that predicts every field and pop from the pushed bytes.
module tb_argument_pop_scheduler;

    typedef struct packed {
        logic [1:0] op;
        logic [3:0] len;
        logic [7:0] data;
    } field_t;

    logic        clk;
    logic        rst;
    logic        en;
    logic [7:0]  dec_q;
    logic        dec_ready;
    logic [3:0]  dec_pop;
    logic        arg_valid;
    logic        arg_ready;
    logic [1:0]  arg_op;
    logic [3:0]  arg_len;
    logic [7:0]  arg_data;
    logic        busy;
`ifdef ARG_SCHED_COUNT_EN
    logic [15:0] arg_count;
`endif

    argument_pop_scheduler #(.WIDTH_OUT(8), .LOG2_WIDTH_OUT(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .dec_q     (dec_q),
        .dec_ready (dec_ready),
        .dec_pop   (dec_pop),
        .arg_valid (arg_valid),
        .arg_ready (arg_ready),
        .arg_op    (arg_op),
        .arg_len   (arg_len),
        .arg_data  (arg_data),
`ifdef ARG_SCHED_COUNT_EN
        .arg_count (arg_count),
`endif
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Decoder side: bytes handed over by the stimulus, bits currently held.
    logic [7:0] push_bytes [4096];
    int         push_wr = 0;
    int         rd_ptr  = 0;
    bit         dq [$];

    // Reference model: whole stream since reset and the fields/pops it implies.
    bit         mbits [$];
    int         mpos;
    field_t     exp_fields [$];
    int         exp_pops [$];

    // Observed behaviour since reset.
    field_t     act_fields [$];
    int         act_pops [$];
    int         n_xfer;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One field needs >= 8 held bits when its header, escape and argument are each taken.
    function automatic bit model_step();
        int     p;
        int     len;
        field_t f;
        p = mpos;
        if (mbits.size() - p < 8) return 1'b0;
        f.op = {mbits[p+1], mbits[p]};
        p += 2;
        if (f.op == 2'b11) begin
            if (mbits.size() - p < 8) return 1'b0;
            len = 4 * int'(mbits[p+2]) + 2 * int'(mbits[p+1]) + int'(mbits[p]);
            if (len == 0) len = 8;
            p += 3;
        end else begin
            len = 1 << f.op;
        end
        if (mbits.size() - p < 8) return 1'b0;
        f.len  = 4'(len);
        f.data = '0;
        for (int i = 0; i < len; i++) f.data[i] = mbits[p+i];
        exp_fields.push_back(f);
        exp_pops.push_back(2);
        if (f.op == 2'b11) exp_pops.push_back(3);
        exp_pops.push_back(len);
        mpos = p + len;
        return 1'b1;
    endfunction

    task automatic push(input logic [7:0] b);
        push_bytes[push_wr] = b;
        push_wr++;
        for (int i = 0; i < 8; i++) mbits.push_back(b[i]);
        while (model_step()) ;
    endtask

    function automatic void refresh_window();
        logic [7:0] w;
        w = '0;
        if (!rst) begin
            dec_q     = 8'hFF;
            dec_ready = 1'b1;
        end else begin
            for (int i = 0; i < 8; i++) if (i < dq.size()) w[i] = dq[i];
            dec_q     = w;
            dec_ready = (dq.size() >= 8);
        end
    endfunction

    function automatic field_t act_at(input int i);
        return (i < act_fields.size()) ? act_fields[i] : field_t'('1);
    endfunction

    function automatic int pop_at(input int i);
        return (i < act_pops.size()) ? act_pops[i] : -1;
    endfunction

    // Compare at negedge, then behave as the decoder just after the rising edge.
    task automatic env_loop();
        field_t     f;
        field_t     prev_f;
        logic       prev_hold;
        logic [3:0] prev_pop;
        logic       rst_s;
        logic [3:0] pop_s;
        prev_f    = '0;
        prev_hold = 1'b0;
        prev_pop  = '0;
        forever begin
            @(negedge clk);
            rst_s = rst;
            pop_s = dec_pop;
            f     = {arg_op, arg_len, arg_data};
            if (!rst) begin
                act_fields.delete();
                act_pops.delete();
                n_xfer    = 0;
                prev_hold = 1'b0;
                prev_pop  = '0;
            end else begin
                if (prev_hold) check("hold_stable", 32'({arg_valid, f}), 32'({1'b1, prev_f}));
                if (arg_valid && arg_ready) begin
                    act_fields.push_back(f);
                    check("field_in_model", 32'(n_xfer < exp_fields.size()), 32'd1);
                    if (n_xfer < exp_fields.size())
                        check("field", 32'(f), 32'(exp_fields[n_xfer]));
                    n_xfer++;
                end
                if (dec_pop != 0) begin
                    act_pops.push_back(int'(dec_pop));
                    check("pop_gap", 32'(prev_pop), 32'd0);
                end
                prev_hold = arg_valid && !arg_ready;
                prev_f    = f;
                prev_pop  = dec_pop;
            end
            refresh_window();
            @(posedge clk);
            #1;
            if (!rst_s) begin
                dq.delete();
                rd_ptr = push_wr;
            end else begin
                if (pop_s != 0) begin
                    check("pop_within_window", 32'(int'(pop_s) <= dq.size()), 32'd1);
                    repeat (int'(pop_s)) if (dq.size() > 0) void'(dq.pop_front());
                end
                while (rd_ptr != push_wr) begin
                    for (int b = 0; b < 8; b++) dq.push_back(push_bytes[rd_ptr][b]);
                    rd_ptr++;
                end
            end
            refresh_window();
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b0;
        mbits.delete();
        exp_fields.delete();
        exp_pops.delete();
        mpos = 0;
        repeat (cycles) tick();
        rst = 1'b1;
    endtask

    task automatic finish_segment(input bit full);
        int n;
        if (full) en = 1'b1;
        arg_ready = 1'b1;
        repeat (200) tick();
        if (full) begin
            check("xfer_count", 32'(n_xfer), 32'(exp_fields.size()));
            check("pop_count_min", 32'(act_pops.size() >= exp_pops.size()), 32'd1);
`ifdef ARG_SCHED_COUNT_EN
            check("arg_count", 32'(arg_count), 32'(n_xfer));
`endif
        end
        n = (act_pops.size() < exp_pops.size()) ? act_pops.size() : exp_pops.size();
        for (int i = 0; i < n; i++) check("pop_seq", 32'(act_pops[i]), 32'(exp_pops[i]));
    endtask

    task automatic wait_header_pop(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            if (dec_pop == 4'd2) seen = 1'b1;
        end
        check(name, 32'(seen), 32'd1);
    endtask

    task automatic random_segment();
        int nb;
        int pushed;
        nb     = $urandom_range(3, 10);
        pushed = 0;
        do_reset(2);
        while (pushed < nb) begin
            en        = ($urandom_range(0, 7) != 0);
            arg_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 2) == 0) begin
                push(8'($urandom));
                pushed++;
            end
            tick();
        end
        finish_segment(1'b1);
    endtask

    task automatic stimulus();
        // Reset with a full-looking window must keep everything idle.
        en        = 1'b1;
        arg_ready = 1'b1;
        do_reset(5);
        rst = 1'b0;
        check("rst_dec_pop", 32'(dec_pop), 32'd0);
        check("rst_arg_valid", 32'(arg_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_arg_fields", 32'({arg_op, arg_len, arg_data}), 32'd0);

        // Escape header 11, escape value 2, two-bit argument.
        do_reset(2);
        push(8'hAB); push(8'h00); push(8'h00);
        finish_segment(1'b1);
        check("t2_field0", 32'(act_at(0)), 32'(14'({2'd3, 4'd2, 8'h01})));
        check("t2_pop0", 32'(pop_at(0)), 32'd2);
        check("t2_pop1", 32'(pop_at(1)), 32'd3);
        check("t2_pop2", 32'(pop_at(2)), 32'd2);
        check("t2_model_fields", 32'(exp_fields.size()), 32'd4);

        // One-bit arguments, including ones taken from zero padding.
        do_reset(2);
        push(8'h04); push(8'h00);
        finish_segment(1'b1);
        check("t3_field0", 32'(act_at(0)), 32'(14'({2'd0, 4'd1, 8'h01})));
        check("t3_field1", 32'(act_at(1)), 32'(14'({2'd0, 4'd1, 8'h00})));
        check("t3_model_fields", 32'(exp_fields.size()), 32'd3);

        // Escape value 000 means a full eight-bit argument.
        do_reset(2);
        push(8'hE3); push(8'h1F); push(8'h00);
        finish_segment(1'b1);
        check("t4_field0", 32'(act_at(0)), 32'(14'({2'd3, 4'd8, 8'hFF})));
        check("t4_pop2", 32'(pop_at(2)), 32'd8);

        // Back-pressure with fields queued, then release.
        do_reset(2);
        arg_ready = 1'b0;
        push(8'h00); push(8'h00); push(8'h00); push(8'h00);
        repeat (20) tick();
        check("t5_valid_held", 32'(arg_valid), 32'd1);
        check("t5_parked_pop", 32'(dec_pop), 32'd0);
        check("t5_busy", 32'(busy), 32'd1);
        check("t5_model_fields", 32'(exp_fields.size()), 32'd8);
        finish_segment(1'b1);

        // Dropping en after a header is taken still completes that field.
        do_reset(2);
        push(8'h00); push(8'h00); push(8'h00);
        wait_header_pop("t6_header_seen");
        en = 1'b0;
        repeat (30) tick();
        check("t6_one_field", 32'(n_xfer), 32'd1);
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_idle_pop", 32'(dec_pop), 32'd0);
`ifdef ARG_SCHED_COUNT_EN
        check("t6_arg_count", 32'(arg_count), 32'd1);
`endif
        finish_segment(1'b0);

        // Reset mid-field drops it and issues no pop.
        en = 1'b1;
        do_reset(2);
        push(8'h00); push(8'h00); push(8'h00);
        wait_header_pop("t7_header_seen");
        do_reset(1);
        check("t7_pop", 32'(dec_pop), 32'd0);
        check("t7_valid", 32'(arg_valid), 32'd0);
        check("t7_busy", 32'(busy), 32'd0);

        for (int s = 0; s < 14; s++) random_segment();
    endtask

    initial begin
        rst       = 1'b0;
        en        = 1'b0;
        arg_ready = 1'b0;
        dec_q     = 8'hFF;
        dec_ready = 1'b1;
        mpos      = 0;
        n_xfer    = 0;
        fork
            env_loop();
        join_none
        stimulus();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
